// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single-port word memory between instruction fetch (if_*) and
//   load/store (d_*). Each access is an ACCESS cycle (memory op, *_gnt high)
//   followed by a DONE cycle (*_valid pulse, registered read data). The data
//   port has priority. A saturating wait counter lets fetch win after
//   MAX_WAIT consecutive lost arbitrations.
//
// Ports
//   arb_clk, arb_rst_n          clock, async active-low reset
//   if_req/if_addr              fetch request (always a read)
//   if_gnt/if_valid/if_rdata    fetch grant, response pulse, held read word
//   d_req/d_we/d_addr/d_wdata   data request
//   d_gnt/d_valid/d_rdata       data grant, response pulse, held read word
//   arb_err                     misaligned address flag, coincident with valid
//   mem_rd/mem_wr/mem_addr/mem_wr_data/mem_rd_data   memory side
//   arb_busy                    high in ACCESS or DONE
module mem_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        arb_clk,
   input  logic        arb_rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        arb_err,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wr_data,
   input  logic [31:0] mem_rd_data,
   output logic        arb_busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   logic [1:0]  state;
   logic        own_d;      // 1 = data port owns the current access
   logic        lat_we;
   logic        lat_mis;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  wait_cnt;
   logic [31:0] if_rdata_q;
   logic [31:0] d_rdata_q;

   logic        arb_now;
   logic        fetch_wins;
   logic [31:0] win_addr;

   // Arbitration happens on any IDLE or DONE edge with a pending request.
   assign arb_now    = ((state == ST_IDLE) || (state == ST_DONE)) && (if_req || d_req);
   assign fetch_wins = if_req && (!d_req || (wait_cnt == WAIT_LIMIT));
   assign win_addr   = fetch_wins ? if_addr : d_addr;

   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         state      <= ST_IDLE;
         own_d      <= 1'b0;
         lat_we     <= 1'b0;
         lat_mis    <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         case (state)
            ST_ACCESS: begin
               if (!lat_we) begin
                  if (own_d) d_rdata_q  <= mem_rd_data;
                  else       if_rdata_q <= mem_rd_data;
               end
               state <= ST_DONE;
            end
            default: begin
               if (arb_now) begin
                  own_d    <= !fetch_wins;
                  lat_we   <= fetch_wins ? 1'b0 : d_we;
                  lat_addr <= {win_addr[31:2], 2'b00};
                  lat_mis  <= |win_addr[1:0];
                  // Fetch never writes, so keep the previous store data on the bus.
                  if (!fetch_wins) lat_wdata <= d_wdata;
                  state    <= ST_ACCESS;
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Counts consecutive arbitrations fetch lost; any edge without if_req clears it.
   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         wait_cnt <= '0;
      end else if (!if_req) begin
         wait_cnt <= '0;
      end else if (arb_now) begin
         if (fetch_wins)                   wait_cnt <= '0;
         else if (wait_cnt != WAIT_LIMIT)  wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Strobes decode straight from state so an async reset drops mem_wr at once.
   assign if_gnt      = (state == ST_ACCESS) && !own_d;
   assign d_gnt       = (state == ST_ACCESS) &&  own_d;
   assign mem_rd      = (state == ST_ACCESS) && !lat_we;
   assign mem_wr      = (state == ST_ACCESS) &&  lat_we;
   assign if_valid    = (state == ST_DONE)   && !own_d;
   assign d_valid     = (state == ST_DONE)   &&  own_d;
   assign arb_err     = (state == ST_DONE)   &&  lat_mis;
   assign arb_busy    = (state != ST_IDLE);
   assign mem_addr    = lat_addr;
   assign mem_wr_data = lat_wdata;
   assign if_rdata    = if_rdata_q;
   assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        arb_clk;
   logic        arb_rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        arb_err;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;
   logic        arb_busy;

   mem_arbiter #(.MAX_WAIT(4)) dut (
      .arb_clk     (arb_clk),
      .arb_rst_n   (arb_rst_n),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_gnt      (if_gnt),
      .if_valid    (if_valid),
      .if_rdata    (if_rdata),
      .d_req       (d_req),
      .d_we        (d_we),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_gnt       (d_gnt),
      .d_valid     (d_valid),
      .d_rdata     (d_rdata),
      .arb_err     (arb_err),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data),
      .arb_busy    (arb_busy)
   );

   initial arb_clk = 1'b0;
   always #5 arb_clk = ~arb_clk;

   // Word memory model: combinational read, write on the edge ending ACCESS.
   logic        preload;
   logic [31:0] mem [256];
   assign mem_rd_data = mem[mem_addr[9:2]];

   always @(posedge arb_clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem[4]  <= 32'h8C01_0004;
         mem[5]  <= 32'h0022_1820;
         mem[16] <= 32'h1111_1111;
      end else if (mem_wr) begin
         mem[mem_addr[9:2]] <= mem_wr_data;
      end
   end

   int n_vec = 0;
   int n_mis = 0;
   logic [31:0] exp_if_rd;
   logic [31:0] exp_d_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        is_if;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_maddr;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vt [9];

   // Single isolated transaction; called and returns at a negedge in IDLE.
   task automatic run_vec(input vec_t v);
      logic rd;
      rd = v.is_if || !v.we;
      if_req  = v.is_if;
      if_addr = v.addr;
      d_req   = !v.is_if;
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wdata;
      @(negedge arb_clk);
      chk("acc_if_gnt", if_gnt, v.is_if);
      chk("acc_d_gnt", d_gnt, !v.is_if);
      chk("acc_mem_rd", mem_rd, rd);
      chk("acc_mem_wr", mem_wr, !rd);
      chk("acc_mem_addr", mem_addr, v.exp_maddr);
      if (!rd) chk("acc_mem_wr_data", mem_wr_data, v.wdata);
      chk("acc_valid", {if_valid, d_valid}, 2'b00);
      if_req = 1'b0;
      d_req  = 1'b0;
      if (rd) begin
         if (v.is_if) exp_if_rd = v.exp_rdata;
         else         exp_d_rd  = v.exp_rdata;
      end
      @(negedge arb_clk);
      chk("done_if_valid", if_valid, v.is_if);
      chk("done_d_valid", d_valid, !v.is_if);
      chk("done_err", arb_err, v.exp_err);
      chk("done_rdwr", {mem_rd, mem_wr, if_gnt, d_gnt}, 4'b0000);
      chk("done_if_rdata", if_rdata, exp_if_rd);
      chk("done_d_rdata", d_rdata, exp_d_rd);
      chk("done_busy", arb_busy, 1'b1);
      @(negedge arb_clk);
      chk("idle_busy", arb_busy, 1'b0);
      chk("idle_err", arb_err, 1'b0);
   endtask

   // Both ports request continuously; exp_if[k] = 1 when grant k goes to fetch.
   // drop_at >= 0 lowers if_req over the DONE edge after grant drop_at.
   task automatic run_contention(input int n, input logic [15:0] exp_if, input int drop_at);
      if_req  = 1'b1;
      if_addr = 32'h10;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h20;
      for (int k = 0; k < n; k++) begin
         @(negedge arb_clk);
         if (drop_at >= 0 && k == drop_at + 1) if_req = 1'b1;
         chk("cont_if_gnt", if_gnt, exp_if[k]);
         chk("cont_d_gnt", d_gnt, !exp_if[k]);
         @(negedge arb_clk);
         chk("cont_if_valid", if_valid, exp_if[k]);
         chk("cont_d_valid", d_valid, !exp_if[k]);
         chk("cont_done_gnt", {if_gnt, d_gnt}, 2'b00);
         if (drop_at >= 0 && k == drop_at) if_req = 1'b0;
         if (k == n - 1) begin
            if_req = 1'b0;
            d_req  = 1'b0;
         end
      end
      @(negedge arb_clk);
      chk("cont_idle_busy", arb_busy, 1'b0);
      chk("cont_if_rdata", if_rdata, 32'h8C01_0004);
      chk("cont_d_rdata", d_rdata, 32'hDEAD_BEEF);
   endtask

   initial begin
      vec_t rb;
      //           is_if we   addr          wdata          maddr         rdata          err
      vt[0] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h10, 32'h8C01_0004, 1'b0};
      vt[1] = '{1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h20, 32'h0,         1'b0};
      vt[2] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'h20, 32'hDEAD_BEEF, 1'b0};
      vt[3] = '{1'b0, 1'b0, 32'h23, 32'h0,         32'h20, 32'hDEAD_BEEF, 1'b1};
      vt[4] = '{1'b1, 1'b1, 32'h22, 32'h5555_5555, 32'h20, 32'hDEAD_BEEF, 1'b1};
      vt[5] = '{1'b0, 1'b1, 32'h45, 32'h0BAD_F00D, 32'h44, 32'h0,         1'b1};
      vt[6] = '{1'b0, 1'b0, 32'h44, 32'h0,         32'h44, 32'h0BAD_F00D, 1'b0};
      vt[7] = '{1'b1, 1'b0, 32'h14, 32'h0,         32'h14, 32'h0022_1820, 1'b0};
      vt[8] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'h10, 32'h8C01_0004, 1'b0};

      exp_if_rd = '0;
      exp_d_rd  = '0;

      // Reset with requests active
      preload   = 1'b1;
      arb_rst_n = 1'b0;
      if_req    = 1'b1;
      if_addr   = 32'h10;
      d_req     = 1'b1;
      d_we      = 1'b1;
      d_addr    = 32'h20;
      d_wdata   = 32'hFFFF_FFFF;
      repeat (2) @(posedge arb_clk);
      @(negedge arb_clk);
      chk("rst_if_gnt", if_gnt, 1'b0);
      chk("rst_if_valid", if_valid, 1'b0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_gnt", d_gnt, 1'b0);
      chk("rst_d_valid", d_valid, 1'b0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_err", arb_err, 1'b0);
      chk("rst_mem_rd", mem_rd, 1'b0);
      chk("rst_mem_wr", mem_wr, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wr_data", mem_wr_data, 32'h0);
      chk("rst_busy", arb_busy, 1'b0);
      if_req    = 1'b0;
      d_req     = 1'b0;
      preload   = 1'b0;
      arb_rst_n = 1'b1;
      @(negedge arb_clk);
      chk("rel_busy", arb_busy, 1'b0);
      chk("rel_gnt", {if_gnt, d_gnt}, 2'b00);

      for (int i = 0; i < 9; i++) run_vec(vt[i]);

      // Write immediately followed by a read of the same word
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h30;
      d_wdata = 32'hCAFE_F00D;
      @(negedge arb_clk);
      chk("haz_wr", mem_wr, 1'b1);
      chk("haz_wr_addr", mem_addr, 32'h30);
      @(negedge arb_clk);
      chk("haz_wr_valid", d_valid, 1'b1);
      d_we = 1'b0;
      @(negedge arb_clk);
      chk("haz_rd", mem_rd, 1'b1);
      chk("haz_rd_gnt", d_gnt, 1'b1);
      d_req = 1'b0;
      @(negedge arb_clk);
      chk("haz_rd_valid", d_valid, 1'b1);
      chk("haz_rdata", d_rdata, 32'hCAFE_F00D);
      @(negedge arb_clk);
      chk("haz_idle", arb_busy, 1'b0);
      mem_rb_fix();

      // Order D,D,D,D,IF,D,D,D,D,IF
      run_contention(10, 16'b0000_0010_0001_0000, -1);
      // Dropping if_req clears the counter: D,D,D then four more D before IF
      run_contention(9, 16'b0000_0000_1000_0000, 1);

      // Reset during the ACCESS cycle of a write
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h40;
      d_wdata = 32'h1234_5678;
      @(negedge arb_clk);
      chk("mrst_wr_before", mem_wr, 1'b1);
      #1 arb_rst_n = 1'b0;
      #1;
      chk("mrst_wr_after", mem_wr, 1'b0);
      chk("mrst_gnt", d_gnt, 1'b0);
      chk("mrst_busy", arb_busy, 1'b0);
      d_req = 1'b0;
      @(posedge arb_clk);
      @(negedge arb_clk);
      chk("mrst_valid", d_valid, 1'b0);
      chk("mrst_mem_word", mem[16], 32'h1111_1111);
      arb_rst_n = 1'b1;
      exp_if_rd = '0;
      exp_d_rd  = '0;
      @(negedge arb_clk);
      rb = '{1'b0, 1'b0, 32'h40, 32'h0, 32'h40, 32'h1111_1111, 1'b0};
      run_vec(rb);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   // After the hazard sequence the model's last data read is the hazard word.
   task automatic mem_rb_fix();
      exp_d_rd = 32'hCAFE_F00D;
   endtask

   // Absolute time bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
